// File: rtl/blink_bank_mapper.sv
`timescale 1ns/1ps
// Blink MMU: COM and SR0..SR3 registers on Z80 IO, 16-bit to banked address
// translation, slot decode and per-region wait-state insertion.
module blink_bank_mapper #(
  parameter int         BANK_W    = 8,
  parameter logic [7:0] IO_BASE   = 8'hD0,
  parameter logic [7:0] COM_ADDR  = 8'hB0,
  parameter logic [7:0] RAMS_BANK = 8'h20,
  parameter int         WS_ROM    = 0,
  parameter int         WS_RAM    = 0,
  parameter int         WS_CARD   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       z80_a,
  input  logic [7:0]        z80_do,
  input  logic              z80_mreq_n,
  input  logic              z80_iorq_n,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  input  logic              z80_m1_n,
  output logic [BANK_W+13:0] mem_a,
  output logic              rom_sel,
  output logic              ram_sel,
  output logic [2:0]        card_sel,
  output logic              io_hit,
  output logic [7:0]        io_do,
  output logic [7:0]        com_out,
  output logic              z80_wait_n
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  logic [7:0]        com_q, com_d;
  logic [7:0]        sr_q [4];
  logic [7:0]        sr_d [4];
  logic [7:0]        io_do_q, io_do_d;
  logic              mreq_q, mreq_d;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              io_wr, io_rd, com_hit;
  logic [3:0]        sr_hit;
  logic [BANK_W-1:0] bank;
  logic [1:0]        slot;
  logic              mem_req;
  logic [3:0]        ws_n;
  logic              start;

  always_comb begin
    io_wr   = ~z80_iorq_n & ~z80_wr_n & z80_m1_n;
    io_rd   = ~z80_iorq_n & ~z80_rd_n & z80_m1_n;
    com_hit = (z80_a[7:0] == COM_ADDR);
    for (int k = 0; k < 4; k++) begin
      sr_hit[k] = (z80_a[7:0] == IO_BASE + 8'(k));
    end
  end

  always_comb begin
    com_d   = com_q;
    sr_d    = sr_q;
    io_do_d = io_do_q;
    io_hit  = 1'b0;
    if (io_wr && com_hit) begin
      com_d = z80_do;
    end
    for (int k = 0; k < 4; k++) begin
      if (io_wr && sr_hit[k]) begin
        sr_d[k] = z80_do;
      end
    end
    if (io_rd && com_hit) begin
      io_hit  = 1'b1;
      io_do_d = com_q;
    end
    for (int k = 0; k < 4; k++) begin
      if (io_rd && sr_hit[k]) begin
        io_hit  = 1'b1;
        io_do_d = sr_q[k];
      end
    end
  end

  // Segment 0 splits in two: the upper 8K follows SR0, the lower 8K is either
  // bank 0 or the RAMS bank depending on COM[2].
  always_comb begin
    bank = '0;
    case (z80_a[15:14])
      2'b11:   bank = sr_q[3][BANK_W-1:0];
      2'b10:   bank = sr_q[2][BANK_W-1:0];
      2'b01:   bank = sr_q[1][BANK_W-1:0];
      default: begin
        if (z80_a[13]) begin
          bank = sr_q[0][BANK_W-1:0];
        end else if (com_q[2]) begin
          bank = RAMS_BANK[BANK_W-1:0];
        end else begin
          bank = '0;
        end
      end
    endcase
  end

  assign mem_a    = {bank, z80_a[13:0]};
  assign slot     = bank[BANK_W-1 -: 2];
  assign mem_req  = ~z80_mreq_n;
  assign rom_sel  = mem_req & (slot == 2'd0) & ~bank[BANK_W-3];
  assign ram_sel  = mem_req & (slot == 2'd0) & bank[BANK_W-3];
  assign card_sel = {3{mem_req}} & {slot == 2'd3, slot == 2'd2, slot == 2'd1};
  assign ws_n     = (slot != 2'd0) ? 4'(WS_CARD)
                  : (bank[BANK_W-3] ? 4'(WS_RAM) : 4'(WS_ROM));
  assign start    = ~z80_mreq_n & mreq_q;
  assign mreq_d   = z80_mreq_n;
  assign com_out  = com_q;
  assign io_do    = io_do_q;

  // The start cycle is already the first wait cycle, so COUNT covers the
  // remaining N-1; cnt holds how many COUNT cycles follow the current one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    z80_wait_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ws_n == 4'd0) begin
            state_d = DONE;
          end else begin
            z80_wait_n = 1'b0;
            if (ws_n == 4'd1) begin
              state_d = DONE;
            end else begin
              cnt_d   = ws_n - 4'd2;
              state_d = COUNT;
            end
          end
        end
      end
      COUNT: begin
        if (z80_mreq_n) begin
          state_d = IDLE;
        end else begin
          z80_wait_n = 1'b0;
          if (cnt_q == 4'd0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE: begin
        if (z80_mreq_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mreq_q clears on reset so an access already in flight when reset lifts
  // is not mistaken for a fresh start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      com_q   <= '0;
      sr_q    <= '{default: '0};
      io_do_q <= '0;
      mreq_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      com_q   <= com_d;
      sr_q    <= sr_d;
      io_do_q <= io_do_d;
      mreq_q  <= mreq_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_blink_bank_mapper.sv
`timescale 1ns/1ps
// Randomised self-checking bench for blink_bank_mapper against an
// arithmetic model of the bank registers, translation and wait counts.
module tb_blink_bank_mapper;

  localparam int WS_ROM  = 1;
  localparam int WS_RAM  = 0;
  localparam int WS_CARD = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] z80_a;
  logic [7:0]  z80_do;
  logic        z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic [21:0] mem_a;
  logic        rom_sel, ram_sel, io_hit, z80_wait_n;
  logic [2:0]  card_sel;
  logic [7:0]  io_do, com_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_sr [4];
  logic [7:0] m_com;
  logic [7:0] m_io_do;

  blink_bank_mapper #(
    .BANK_W(8), .IO_BASE(8'hD0), .COM_ADDR(8'hB0), .RAMS_BANK(8'h20),
    .WS_ROM(WS_ROM), .WS_RAM(WS_RAM), .WS_CARD(WS_CARD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .z80_a(z80_a), .z80_do(z80_do),
    .z80_mreq_n(z80_mreq_n), .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n),
    .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n), .mem_a(mem_a),
    .rom_sel(rom_sel), .ram_sel(ram_sel), .card_sel(card_sel),
    .io_hit(io_hit), .io_do(io_do), .com_out(com_out), .z80_wait_n(z80_wait_n)
  );

  always #5 clk = ~clk;

  function automatic int reg_idx(input logic [7:0] port);
    if (port == 8'hB0) return 4;
    if (port >= 8'hD0 && port <= 8'hD3) return int'(port - 8'hD0);
    return -1;
  endfunction

  function automatic logic [7:0] reg_val(input int idx);
    if (idx == 4) return m_com;
    return m_sr[idx[1:0]];
  endfunction

  // Every segment maps to bank*16K + (address mod 16K); only the bank varies.
  function automatic int exp_bank(input logic [15:0] a);
    if (a[15:14] != 2'b00) return int'(m_sr[a[15:14]]);
    if (a[13]) return int'(m_sr[0]);
    return m_com[2] ? 32 : 0;
  endfunction

  function automatic logic [21:0] exp_addr(input logic [15:0] a);
    return 22'(exp_bank(a) * 16384 + int'(a % 16'd16384));
  endfunction

  function automatic int exp_waits(input int b);
    if (b >= 64) return WS_CARD;
    return (b >= 32) ? WS_RAM : WS_ROM;
  endfunction

  function automatic logic [2:0] exp_card(input int b);
    if (b < 64) return 3'b000;
    return 3'(1 << (b / 64 - 1));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_sr[i] = 8'h00;
    m_com   = 8'h00;
    m_io_do = 8'h00;
  endtask

  task automatic bus_idle();
    z80_a = 16'h0000; z80_do = 8'h00;
    z80_mreq_n = 1'b1; z80_iorq_n = 1'b1; z80_rd_n = 1'b1;
    z80_wr_n = 1'b1; z80_m1_n = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data, input logic m1);
    int idx;
    @(posedge clk); #1;
    z80_a = {8'h00, port}; z80_do = data; z80_m1_n = m1;
    z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    idx = reg_idx(port);
    if (m1 && idx == 4) m_com = data;
    else if (m1 && idx >= 0) m_sr[idx[1:0]] = data;
  endtask

  task automatic io_read(input logic [7:0] port, input logic m1,
                         output logic hit, output logic [7:0] d);
    int idx;
    @(posedge clk); #1;
    z80_a = {8'h00, port}; z80_m1_n = m1;
    z80_iorq_n = 1'b0; z80_rd_n = 1'b0;
    @(negedge clk);
    hit = io_hit;
    idx = reg_idx(port);
    if (m1 && idx >= 0) m_io_do = reg_val(idx);
    @(posedge clk); #1;
    d = io_do;
    bus_idle();
  endtask

  task automatic mem_cycle(input logic [15:0] a, output logic [21:0] ma,
                           output logic r, output logic m, output logic [2:0] c,
                           output int waits, output bit timeout);
    @(posedge clk); #1;
    z80_a = a; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    @(negedge clk);
    ma = mem_a; r = rom_sel; m = ram_sel; c = card_sel;
    waits = 0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (z80_wait_n === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    bus_idle();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (com_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_com: got %h want 00", com_out); end
    checks++; if (io_do !== 8'h00) begin failures++; $display("[TB] FAIL reset_io_do: got %h want 00", io_do); end
    checks++; if (z80_wait_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_wait: got %b want 1", z80_wait_n); end
    reset_n = 1'b1;
    mem_cycle(16'h2000, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h002000) begin failures++; $display("[TB] FAIL reset_addr: got %h want 002000", ma); end
    checks++; if ({r, m, c} !== 5'b10000) begin failures++; $display("[TB] FAIL reset_sel: got %b want 10000", {r, m, c}); end
    checks++; if (w !== WS_ROM || to) begin failures++; $display("[TB] FAIL reset_rom_waits: got %0d (timeout %0d) want %0d", w, to, WS_ROM); end
  endtask

  task automatic test_segment();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    io_write(8'hD1, 8'h21, 1'b1);
    mem_cycle(16'h4123, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h084123) begin failures++; $display("[TB] FAIL seg1_addr: got %h want 084123", ma); end
    checks++; if ({r, m, c} !== 5'b01000) begin failures++; $display("[TB] FAIL seg1_sel: got %b want 01000", {r, m, c}); end
    checks++; if (w !== WS_RAM || to) begin failures++; $display("[TB] FAIL seg1_ram_waits: got %0d want %0d", w, WS_RAM); end
  endtask

  task automatic test_com();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    io_write(8'hB0, 8'h04, 1'b1);
    checks++; if (com_out !== 8'h04) begin failures++; $display("[TB] FAIL com_out: got %h want 04", com_out); end
    mem_cycle(16'h0100, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h080100) begin failures++; $display("[TB] FAIL rams_addr: got %h want 080100", ma); end
    checks++; if (m !== 1'b1) begin failures++; $display("[TB] FAIL rams_ram_sel: got %b want 1", m); end
    io_write(8'hB0, 8'h00, 1'b1);
    mem_cycle(16'h0100, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h000100) begin failures++; $display("[TB] FAIL bank0_addr: got %h want 000100", ma); end
  endtask

  task automatic test_io_read();
    logic hit; logic [7:0] d;
    io_write(8'hD2, 8'hC5, 1'b1);
    io_read(8'hD2, 1'b1, hit, d);
    checks++; if (hit !== 1'b1) begin failures++; $display("[TB] FAIL in_d2_hit: got %b want 1", hit); end
    checks++; if (d !== 8'hC5) begin failures++; $display("[TB] FAIL in_d2_data: got %h want c5", d); end
    io_read(8'hD7, 1'b1, hit, d);
    checks++; if (hit !== 1'b0) begin failures++; $display("[TB] FAIL in_d7_hit: got %b want 0", hit); end
    checks++; if (d !== 8'hC5) begin failures++; $display("[TB] FAIL in_d7_hold: got %h want c5", d); end
    io_write(8'hD0, 8'h5A, 1'b1);
    io_read(8'hD0, 1'b0, hit, d);
    checks++; if (hit !== 1'b0 || d !== 8'hC5) begin failures++; $display("[TB] FAIL int_ack_read: got hit %b data %h want 0 c5", hit, d); end
    io_write(8'hD0, 8'hFF, 1'b0);
    io_read(8'hD0, 1'b1, hit, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("[TB] FAIL int_ack_write_ignored: got %h want 5a", d); end
  endtask

  task automatic test_card_wait();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    io_write(8'hD3, 8'hC0, 1'b1);
    mem_cycle(16'hC000, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h300000) begin failures++; $display("[TB] FAIL card_addr: got %h want 300000", ma); end
    checks++; if ({r, m, c} !== 5'b00100) begin failures++; $display("[TB] FAIL card_sel: got %b want 00100", {r, m, c}); end
    checks++; if (w !== 2 || to) begin failures++; $display("[TB] FAIL card_waits: got %0d (timeout %0d) want 2", w, to); end
  endtask

  task automatic test_abort();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    io_write(8'hD3, 8'hC0, 1'b1);
    @(posedge clk); #1;
    z80_a = 16'hC000; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    @(negedge clk);
    checks++; if (z80_wait_n !== 1'b0) begin failures++; $display("[TB] FAIL abort_start_wait: got %b want 0", z80_wait_n); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    checks++; if (z80_wait_n !== 1'b1) begin failures++; $display("[TB] FAIL abort_release: got %b want 1", z80_wait_n); end
    @(posedge clk); #1;
    mem_cycle(16'hC000, ma, r, m, c, w, to);
    checks++; if (w !== WS_CARD || to) begin failures++; $display("[TB] FAIL abort_restart_waits: got %0d want %0d", w, WS_CARD); end
  endtask

  task automatic test_simultaneous();
    logic [21:0] want_old, want_new;
    io_write(8'hD1, 8'h11, 1'b1);
    want_old = exp_addr(16'h40D1);
    @(posedge clk); #1;
    z80_a = 16'h40D1; z80_do = 8'h9C;
    z80_mreq_n = 1'b0; z80_wr_n = 1'b0; z80_iorq_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_a !== want_old) begin failures++; $display("[TB] FAIL simul_old_addr: got %h want %h", mem_a, want_old); end
    m_sr[1] = 8'h9C;
    want_new = exp_addr(16'h40D1);
    @(posedge clk); #1;
    checks++; if (mem_a !== want_new) begin failures++; $display("[TB] FAIL simul_new_addr: got %h want %h", mem_a, want_new); end
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    logic hit; logic [7:0] d, port, data; logic [15:0] a;
    int op, b;
    logic [7:0] ports [6];
    ports[0] = 8'hB0; ports[1] = 8'hD0; ports[2] = 8'hD1;
    ports[3] = 8'hD2; ports[4] = 8'hD3;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      ports[5] = 8'($urandom);
      port = ports[$urandom_range(0, 5)];
      if (op == 0) begin
        data = 8'($urandom);
        io_write(port, data, ($urandom_range(0, 5) != 0));
        checks++; if (com_out !== m_com) begin failures++; $display("[TB] FAIL rand_com_out: got %h want %h", com_out, m_com); end
      end else if (op == 1) begin
        io_read(port, 1'b1, hit, d);
        checks++; if (hit !== (reg_idx(port) >= 0)) begin failures++; $display("[TB] FAIL rand_io_hit %h: got %b", port, hit); end
        checks++; if (d !== m_io_do) begin failures++; $display("[TB] FAIL rand_io_do %h: got %h want %h", port, d, m_io_do); end
      end else begin
        a = 16'($urandom);
        b = exp_bank(a);
        mem_cycle(a, ma, r, m, c, w, to);
        checks++; if (ma !== exp_addr(a)) begin failures++; $display("[TB] FAIL rand_addr %h: got %h want %h", a, ma, exp_addr(a)); end
        checks++; if ({r, m, c} !== {b < 32, b >= 32 && b < 64, exp_card(b)}) begin failures++; $display("[TB] FAIL rand_sel %h: got %b bank %0d", a, {r, m, c}, b); end
        checks++; if (w !== exp_waits(b) || to) begin failures++; $display("[TB] FAIL rand_waits %h: got %0d want %0d", a, w, exp_waits(b)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] ma; logic r, m; logic [2:0] c; int w; bit to;
    logic hit; logic [7:0] d;
    io_write(8'hD3, 8'hC0, 1'b1);
    io_write(8'hB0, 8'h04, 1'b1);
    @(posedge clk); #1;
    z80_a = 16'hC000; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    model_clear();
    checks++; if (z80_wait_n !== 1'b1) begin failures++; $display("[TB] FAIL midreset_wait: got %b want 1", z80_wait_n); end
    checks++; if (com_out !== 8'h00 || io_do !== 8'h00) begin failures++; $display("[TB] FAIL midreset_regs: got com %h io_do %h want 00 00", com_out, io_do); end
    checks++; if (mem_a !== 22'h000000) begin failures++; $display("[TB] FAIL midreset_sr3: got %h want 000000", mem_a); end
    bus_idle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    io_read(8'hD3, 1'b1, hit, d);
    checks++; if (hit !== 1'b1 || d !== 8'h00) begin failures++; $display("[TB] FAIL midreset_read_sr3: got hit %b data %h want 1 00", hit, d); end
    mem_cycle(16'hC000, ma, r, m, c, w, to);
    checks++; if (ma !== 22'h000000 || r !== 1'b1) begin failures++; $display("[TB] FAIL midreset_access: got %h rom %b want 000000 1", ma, r); end
    checks++; if (w !== WS_ROM || to) begin failures++; $display("[TB] FAIL midreset_waits: got %0d want %0d", w, WS_ROM); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_segment();
    test_com();
    test_io_read();
    test_card_wait();
    test_abort();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
